// File: rtl/xxhash32_stream.sv
// ============================================================================
//  Module   : xxhash32_stream
//  Purpose  : Streaming XXH32 digest of a byte-granular message delivered as
//             32-bit little-endian words over a valid/ready handshake.
//             One 16-byte stripe is absorbed per four accepted full words.
//  Ports    : clk, rst (async, active-high)
//             start, seed_in           - begin a new message with a seed
//             in_valid/in_ready        - word handshake
//             in_data, in_last, in_bytes - word, last flag, valid bytes (0..4)
//             hash_valid, output_hash  - digest and its qualifier
//             msg_len                  - byte count (only with XXHASH_LEN_OUT_EN)
//  Config   : `define XXHASH_LEN_OUT_EN to expose the byte-length counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xxhash32_stream #(
    parameter int LEN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_last,
    input  logic [2:0]           in_bytes,
    output logic                 hash_valid,
    output logic [31:0]          output_hash
`ifdef XXHASH_LEN_OUT_EN
    ,
    output logic [LEN_WIDTH-1:0] msg_len
`endif
);

    localparam logic [31:0] C_P1 = 32'h9E3779B1;
    localparam logic [31:0] C_P2 = 32'h85EBCA77;
    localparam logic [31:0] C_P3 = 32'hC2B2AE3D;
    localparam logic [31:0] C_P4 = 32'h27D4EB2F;
    localparam logic [31:0] C_P5 = 32'h165667B1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABSORB = 3'd1,
        S_MERGE  = 3'd2,
        S_TAIL_W = 3'd3,
        S_TAIL_B = 3'd4,
        S_AVAL1  = 3'd5,
        S_AVAL2  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] lane_round(input logic [31:0] v, input logic [31:0] w);
        return rotl(v + w * C_P2, 13) * C_P1;
    endfunction

    state_t               r_state;
    logic [31:0]          r_v1, r_v2, r_v3, r_v4;
    logic [31:0]          r_seed;
    logic [31:0]          r_buf0, r_buf1, r_buf2;
    logic [1:0]           r_buf_cnt;
    logic                 r_stripe_seen;
    logic [LEN_WIDTH-1:0] r_len;
    logic [23:0]          r_tail;
    logic [1:0]           r_tail_cnt;
    logic [1:0]           r_widx;
    logic [31:0]          r_acc;
    logic [31:0]          r_hash;
    logic                 r_hash_valid;

    logic        w_xfer;
    logic [2:0]  w_nbytes;
    logic        w_full;
    logic [31:0] w_tail_word;
    logic [31:0] w_converge;
    logic [31:0] w_av1;
    logic [31:0] w_av2a;
    logic [31:0] w_av2b;

    // start wins over a word presented in the same cycle
    assign w_xfer   = (r_state == S_ABSORB) && in_valid && !start;
    assign w_nbytes = !in_last ? 3'd4 : ((in_bytes > 3'd4) ? 3'd4 : in_bytes);
    assign w_full   = (w_nbytes == 3'd4);

    assign w_converge = rotl(r_v1, 1) + rotl(r_v2, 7) + rotl(r_v3, 12) + rotl(r_v4, 18);
    assign w_av1      = (r_acc ^ (r_acc >> 15)) * C_P2;
    assign w_av2a     = (r_acc ^ (r_acc >> 13)) * C_P3;
    assign w_av2b     = w_av2a ^ (w_av2a >> 16);

    always_comb begin
        w_tail_word = r_buf0;
        case (r_widx)
            2'd1:    w_tail_word = r_buf1;
            2'd2:    w_tail_word = r_buf2;
            default: w_tail_word = r_buf0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_v1          <= '0;
            r_v2          <= '0;
            r_v3          <= '0;
            r_v4          <= '0;
            r_seed        <= '0;
            r_buf0        <= '0;
            r_buf1        <= '0;
            r_buf2        <= '0;
            r_buf_cnt     <= '0;
            r_stripe_seen <= 1'b0;
            r_len         <= '0;
            r_tail        <= '0;
            r_tail_cnt    <= '0;
            r_widx        <= '0;
            r_acc         <= '0;
            r_hash        <= '0;
            r_hash_valid  <= 1'b0;
        end else if (start) begin
            r_state       <= S_ABSORB;
            r_v1          <= seed_in + C_P1 + C_P2;
            r_v2          <= seed_in + C_P2;
            r_v3          <= seed_in;
            r_v4          <= seed_in - C_P1;
            r_seed        <= seed_in;
            r_buf_cnt     <= '0;
            r_stripe_seen <= 1'b0;
            r_len         <= '0;
            r_tail_cnt    <= '0;
            r_widx        <= '0;
            r_hash_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_ABSORB: begin
                    if (w_xfer) begin
                        r_len <= r_len + LEN_WIDTH'(w_nbytes);
                        if (w_full) begin
                            if (r_buf_cnt == 2'd3) begin
                                // fourth word completes the stripe: all lanes at once
                                r_v1          <= lane_round(r_v1, r_buf0);
                                r_v2          <= lane_round(r_v2, r_buf1);
                                r_v3          <= lane_round(r_v3, r_buf2);
                                r_v4          <= lane_round(r_v4, in_data);
                                r_buf_cnt     <= 2'd0;
                                r_stripe_seen <= 1'b1;
                            end else begin
                                case (r_buf_cnt)
                                    2'd0:    r_buf0 <= in_data;
                                    2'd1:    r_buf1 <= in_data;
                                    default: r_buf2 <= in_data;
                                endcase
                                r_buf_cnt <= r_buf_cnt + 2'd1;
                            end
                        end else begin
                            // partial last word: kept as tail bytes only
                            r_tail     <= in_data[23:0];
                            r_tail_cnt <= w_nbytes[1:0];
                        end
                        if (in_last) begin
                            r_state <= S_MERGE;
                        end
                    end
                end
                S_MERGE: begin
                    r_acc  <= (r_stripe_seen ? w_converge : (r_seed + C_P5)) + 32'(r_len);
                    r_widx <= 2'd0;
                    if (r_buf_cnt != 2'd0) begin
                        r_state <= S_TAIL_W;
                    end else if (r_tail_cnt != 2'd0) begin
                        r_state <= S_TAIL_B;
                    end else begin
                        r_state <= S_AVAL1;
                    end
                end
                S_TAIL_W: begin
                    r_acc  <= rotl(r_acc + w_tail_word * C_P3, 17) * C_P4;
                    r_widx <= r_widx + 2'd1;
                    if (r_widx == r_buf_cnt - 2'd1) begin
                        r_state <= (r_tail_cnt != 2'd0) ? S_TAIL_B : S_AVAL1;
                    end
                end
                S_TAIL_B: begin
                    r_acc      <= rotl(r_acc + {24'd0, r_tail[7:0]} * C_P5, 11) * C_P1;
                    r_tail     <= {8'd0, r_tail[23:8]};
                    r_tail_cnt <= r_tail_cnt - 2'd1;
                    if (r_tail_cnt == 2'd1) begin
                        r_state <= S_AVAL1;
                    end
                end
                S_AVAL1: begin
                    r_acc   <= w_av1;
                    r_state <= S_AVAL2;
                end
                S_AVAL2: begin
                    r_hash       <= w_av2b;
                    r_hash_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_IDLE, S_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_ABSORB);
    assign hash_valid  = r_hash_valid;
    assign output_hash = r_hash;
`ifdef XXHASH_LEN_OUT_EN
    assign msg_len     = r_len;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xxhash32_stream.sv
// ============================================================================
//  Module   : tb_xxhash32_stream
//  Purpose  : Self-checking bench for xxhash32_stream against a byte-array
//             XXH32 reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xxhash32_stream;

    localparam logic [31:0] C_P1 = 32'h9E3779B1;
    localparam logic [31:0] C_P2 = 32'h85EBCA77;
    localparam logic [31:0] C_P3 = 32'hC2B2AE3D;
    localparam logic [31:0] C_P4 = 32'h27D4EB2F;
    localparam logic [31:0] C_P5 = 32'h165667B1;
    localparam int          C_LEN_WIDTH = 32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] seed_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        hash_valid;
    logic [31:0] output_hash;
`ifdef XXHASH_LEN_OUT_EN
    logic [C_LEN_WIDTH-1:0] msg_len;
`endif

    int checks;
    int errors;
    byte unsigned g_msg[$];

    xxhash32_stream #(.LEN_WIDTH(C_LEN_WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed_in     (seed_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .hash_valid  (hash_valid),
        .output_hash (output_hash)
`ifdef XXHASH_LEN_OUT_EN
        ,
        .msg_len     (msg_len)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (standard byte-oriented XXH32) --------
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int r);
        return (x << r) | (x >> (32 - r));
    endfunction

    function automatic logic [31:0] rd32(input int p);
        return {g_msg[p+3], g_msg[p+2], g_msg[p+1], g_msg[p]};
    endfunction

    function automatic logic [31:0] xxh32_ref(input logic [31:0] seed);
        int n;
        int p;
        logic [31:0] v1, v2, v3, v4, acc;
        n = g_msg.size();
        p = 0;
        if (n >= 16) begin
            v1 = seed + C_P1 + C_P2;
            v2 = seed + C_P2;
            v3 = seed;
            v4 = seed - C_P1;
            while (p + 16 <= n) begin
                v1 = rotl32(v1 + rd32(p)      * C_P2, 13) * C_P1;
                v2 = rotl32(v2 + rd32(p + 4)  * C_P2, 13) * C_P1;
                v3 = rotl32(v3 + rd32(p + 8)  * C_P2, 13) * C_P1;
                v4 = rotl32(v4 + rd32(p + 12) * C_P2, 13) * C_P1;
                p += 16;
            end
            acc = rotl32(v1, 1) + rotl32(v2, 7) + rotl32(v3, 12) + rotl32(v4, 18);
        end else begin
            acc = seed + C_P5;
        end
        acc = acc + 32'(n);
        while (p + 4 <= n) begin
            acc = rotl32(acc + rd32(p) * C_P3, 17) * C_P4;
            p += 4;
        end
        while (p < n) begin
            acc = rotl32(acc + 32'(g_msg[p]) * C_P5, 11) * C_P1;
            p++;
        end
        acc = acc ^ (acc >> 15);
        acc = acc * C_P2;
        acc = acc ^ (acc >> 13);
        acc = acc * C_P3;
        acc = acc ^ (acc >> 16);
        return acc;
    endfunction

    // cycles from last transfer to hash_valid: 3 + buffered words + tail bytes
    function automatic int exp_latency(input int n);
        return 3 + ((n % 16) / 4) + (n % 4);
    endfunction

    // ---------------- stimulus helpers ---------------------------------------
    task automatic do_start(input logic [31:0] s);
        start    = 1'b1;
        seed_in  = s;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        seed_in  = $urandom;
    endtask

    task automatic send_body(input bit gaps, output int drops, output bit tout);
        int n;
        int nw;
        int wi;
        int cyc;
        logic [31:0] w;
        int nb;
        logic rdy;
        n     = g_msg.size();
        nw    = (n == 0) ? 1 : (n + 3) / 4;
        wi    = 0;
        cyc   = 0;
        drops = 0;
        tout  = 1'b0;
        while (wi < nw) begin
            if (cyc > 4000) begin
                tout = 1'b1;
                break;
            end
            w  = '0;
            nb = 0;
            for (int b = 0; b < 4; b++) begin
                if (wi * 4 + b < n) begin
                    w[8*b +: 8] = g_msg[wi*4 + b];
                    nb++;
                end
            end
            in_data = w;
            in_last = (wi == nw - 1);
            if (!in_last)      in_bytes = 3'd4;
            else if (nb == 4)  in_bytes = 3'($urandom_range(4, 7));
            else               in_bytes = 3'(nb);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = in_ready;
            if (!rdy) drops++;
            @(posedge clk);
            if (in_valid && rdy) wi++;
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_hash(output int lat, output bit tout);
        lat = 0;
        while (!hash_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tout = !hash_valid;
    endtask

    task automatic fill_random(input int n);
        g_msg.delete();
        for (int i = 0; i < n; i++) g_msg.push_back(8'($urandom));
    endtask

    // ---------------- test scenarios ----------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
        checks++; if (hash_valid !== 1'b0) begin errors++; $display("FAIL reset_hv got %b want 0", hash_valid); end
        checks++; if (output_hash !== 32'h0) begin errors++; $display("FAIL reset_hash got %h want 0", output_hash); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", in_ready); end
    endtask

    task automatic test_empty;
        int drops; int lat; bit t1; bit t2;
        do_start(32'h0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_ready_after_start got %b want 1", in_ready); end
        g_msg.delete();
        send_body(1'b0, drops, t1);
        wait_hash(lat, t2);
        checks++; if (t1 || t2) begin errors++; $display("FAIL empty_timeout got %b%b want 00", t1, t2); end
        checks++; if (output_hash !== 32'h02CC5D05) begin errors++; $display("FAIL empty_hash got %h want 02cc5d05", output_hash); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL empty_latency got %0d want 3", lat); end
    endtask

    task automatic test_abc;
        int drops; int lat; bit t1; bit t2;
        do_start(32'h0);
        g_msg.delete();
        g_msg.push_back(8'h61); g_msg.push_back(8'h62); g_msg.push_back(8'h63);
        send_body(1'b0, drops, t1);
        wait_hash(lat, t2);
        checks++; if (t1 || t2) begin errors++; $display("FAIL abc_timeout got %b%b want 00", t1, t2); end
        checks++; if (output_hash !== 32'h32D153FF) begin errors++; $display("FAIL abc_hash got %h want 32d153ff", output_hash); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL abc_latency got %0d want 6", lat); end
        // digest must hold in DONE
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hash_valid !== 1'b1 || output_hash !== 32'h32D153FF) begin
            errors++; $display("FAIL abc_hold got %b/%h want 1/32d153ff", hash_valid, output_hash);
        end
    endtask

    task automatic test_19bytes;
        int drops; int lat; bit t1; bit t2; logic [31:0] exp;
        fill_random(19);
        exp = xxh32_ref(32'h9E3779B1);
        do_start(32'h9E3779B1);
        send_body(1'b0, drops, t1);
        wait_hash(lat, t2);
        checks++; if (t1 || t2) begin errors++; $display("FAIL b19_timeout got %b%b want 00", t1, t2); end
        checks++; if (output_hash !== exp) begin errors++; $display("FAIL b19_hash got %h want %h", output_hash, exp); end
        checks++; if (drops !== 0) begin errors++; $display("FAIL b19_ready_drops got %0d want 0", drops); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL b19_latency got %0d want 6", lat); end
    endtask

    task automatic test_restart;
        int drops; int lat; bit t1; bit t2;
        do_start($urandom);
        in_valid = 1'b1; in_last = 1'b0; in_bytes = 3'd4;
        for (int i = 0; i < 2; i++) begin
            in_data = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        do_start(32'h0);
        g_msg.delete();
        send_body(1'b0, drops, t1);
        wait_hash(lat, t2);
        checks++; if (t1 || t2) begin errors++; $display("FAIL restart_timeout got %b%b want 00", t1, t2); end
        checks++; if (output_hash !== 32'h02CC5D05) begin errors++; $display("FAIL restart_hash got %h want 02cc5d05", output_hash); end
    endtask

    task automatic test_reset_mid;
        int drops; int lat; bit t1; bit t2; logic [31:0] exp;
        fill_random(9);
        exp = xxh32_ref(32'h1234_5678);
        do_start(32'h1234_5678);
        send_body(1'b1, drops, t1);
        wait_hash(lat, t2);
        checks++; if (output_hash !== exp) begin errors++; $display("FAIL pre_reset_hash got %h want %h", output_hash, exp); end
        // reset while holding a digest: outputs must clear without a clock edge
        #2 rst = 1'b1;
        #1;
        checks++; if (hash_valid !== 1'b0 || output_hash !== 32'h0) begin
            errors++; $display("FAIL async_reset_done got %b/%h want 0/0", hash_valid, output_hash);
        end
        @(posedge clk); #1 rst = 1'b0;
        // reset in the middle of absorbing
        do_start($urandom);
        in_valid = 1'b1; in_last = 1'b0; in_bytes = 3'd4; in_data = $urandom;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || hash_valid !== 1'b0 || output_hash !== 32'h0) begin
            errors++; $display("FAIL async_reset_absorb got %b/%b/%h want 0/0/0", in_ready, hash_valid, output_hash);
        end
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        do_start(32'h0);
        g_msg.delete();
        send_body(1'b0, drops, t1);
        wait_hash(lat, t2);
        checks++; if (t1 || t2 || output_hash !== 32'h02CC5D05) begin
            errors++; $display("FAIL post_reset_empty got %h want 02cc5d05", output_hash);
        end
    endtask

    task automatic test_random;
        int drops; int lat; bit t1; bit t2; int n; logic [31:0] s; logic [31:0] exp;
        for (int it = 0; it < 40; it++) begin
            n = (it < 16) ? it + 1 : $urandom_range(1, 200);
            s = $urandom;
            fill_random(n);
            exp = xxh32_ref(s);
            do_start(s);
            send_body(1'b1, drops, t1);
            wait_hash(lat, t2);
            checks++; if (t1 || t2) begin errors++; $display("FAIL rnd_timeout len %0d got %b%b want 00", n, t1, t2); end
            checks++; if (output_hash !== exp) begin errors++; $display("FAIL rnd_hash len %0d got %h want %h", n, output_hash, exp); end
            checks++; if (drops !== 0) begin errors++; $display("FAIL rnd_ready_drops len %0d got %0d want 0", n, drops); end
            checks++; if (lat !== exp_latency(n)) begin errors++; $display("FAIL rnd_latency len %0d got %0d want %0d", n, lat, exp_latency(n)); end
`ifdef XXHASH_LEN_OUT_EN
            checks++; if (msg_len !== C_LEN_WIDTH'(n)) begin errors++; $display("FAIL rnd_msg_len got %0d want %0d", msg_len, n); end
`endif
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        seed_in  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = 3'd0;
        #1;
        test_reset;
        test_empty;
        test_abc;
        test_19bytes;
        test_restart;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
